traffic_xing_ctrl: RTL and testbench

TRAFFIC_XING_CTRL -- requirements
Module: traffic_xing_ctrl

---
 rtl/traffic_xing_ctrl.sv | 125 ++++++++++++
 tb/tb_traffic_xing_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_xing_ctrl.sv
// Two-way crossing controller: fixed green/yellow/all-red cycle with a pedestrian walk
// phase, green shortening for pending walkers, and a night-time flashing-yellow mode.
module traffic_xing_ctrl #(
  parameter int CW   = 6,
  parameter int G_T  = 15,
  parameter int Y_T  = 3,
  parameter int AR_T = 2,
  parameter int W_T  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          ped_req,
  input  logic          night,
  output logic [2:0]    ns_lamp,
  output logic [2:0]    ew_lamp,
  output logic          walk,
  output logic [CW-1:0] remain,
  output logic          ped_pend,
  output logic [2:0]    phase
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_NS_G  = 4'd1,
    S_NS_Y  = 4'd2,
    S_AR1   = 4'd3,
    S_EW_G  = 4'd4,
    S_EW_Y  = 4'd5,
    S_AR2   = 4'd6,
    S_PED   = 4'd7,
    S_FLASH = 4'd8
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b001;

  state_t state;
  state_t state_next;
  logic   enter;
  logic   resume_ew;

  function automatic logic [CW-1:0] load_of(input state_t s);
    case (s)
      S_NS_G, S_EW_G: return CW'(G_T - 1);
      S_NS_Y, S_EW_Y: return CW'(Y_T - 1);
      S_AR1, S_AR2:   return CW'(AR_T - 1);
      S_PED:          return CW'(W_T - 1);
      default:        return '0;
    endcase
  endfunction

  // {ns, ew} lamp pattern shown on entry to a state
  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      S_NS_G:  return {GRN, RED};
      S_NS_Y:  return {YEL, RED};
      S_EW_G:  return {RED, GRN};
      S_EW_Y:  return {RED, YEL};
      S_FLASH: return {YEL, YEL};
      default: return {RED, RED};
    endcase
  endfunction

  function automatic logic [2:0] phase_of(input state_t s);
    return (s == S_FLASH) ? 3'd7 : 3'(s);
  endfunction

  always_comb begin
    state_next = state;
    if (state == S_INIT) begin
      state_next = S_NS_G;
    end else if (state == S_FLASH) begin
      if (tick && !night) state_next = S_AR1;
    end else if (tick && remain == '0) begin
      case (state)
        S_NS_G:  state_next = S_NS_Y;
        S_NS_Y:  state_next = S_AR1;
        S_AR1:   state_next = night ? S_FLASH : (ped_pend ? S_PED : S_EW_G);
        S_EW_G:  state_next = S_EW_Y;
        S_EW_Y:  state_next = S_AR2;
        S_AR2:   state_next = night ? S_FLASH : (ped_pend ? S_PED : S_NS_G);
        S_PED:   state_next = resume_ew ? S_EW_G : S_NS_G;
        default: state_next = S_INIT;
      endcase
    end
    enter = (state_next != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      remain    <= '0;
      ns_lamp   <= RED;
      ew_lamp   <= RED;
      walk      <= 1'b0;
      ped_pend  <= 1'b0;
      phase     <= 3'd0;
      resume_ew <= 1'b0;
    end else begin
      // A new request wins over the clear on PED entry
      ped_pend <= ped_req | (ped_pend & ~(enter & (state_next == S_PED)));
      if (enter) begin
        state                <= state_next;
        remain               <= load_of(state_next);
        {ns_lamp, ew_lamp}   <= lamps_of(state_next);
        walk                 <= (state_next == S_PED);
        phase                <= phase_of(state_next);
        if (state_next == S_PED) resume_ew <= (state == S_AR1);
      end else if (tick) begin
        if (state == S_FLASH) begin
          ns_lamp <= ns_lamp ^ YEL;
          ew_lamp <= ew_lamp ^ YEL;
        end else if ((state == S_NS_G || state == S_EW_G) && ped_pend &&
                     remain > CW'(Y_T - 1)) begin
          remain <= CW'(Y_T - 1);
        end else if (remain != '0) begin
          remain <= remain - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_xing_ctrl.sv
// Bench for traffic_xing_ctrl: default and minimal-duration instances share stimulus and
// are compared every cycle against a ticks-left model of the crossing sequence.
module tb_traffic_xing_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, tick = 1'b0, ped_req = 1'b0, night = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] ns0, ew0, ph0, ns1, ew1, ph1;
  logic       wk0, wk1, pp0, pp1;
  logic [5:0] rm0;
  logic [3:0] rm1;

  traffic_xing_ctrl dut0 (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .night(night),
    .ns_lamp(ns0), .ew_lamp(ew0), .walk(wk0), .remain(rm0), .ped_pend(pp0), .phase(ph0));

  traffic_xing_ctrl #(.CW(4), .G_T(15), .Y_T(1), .AR_T(1), .W_T(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .night(night),
    .ns_lamp(ns1), .ew_lamp(ew1), .walk(wk1), .remain(rm1), .ped_pend(pp1), .phase(ph1));

  int tests = 0, fails = 0;
  int G[2] = '{15, 15};
  int Y[2] = '{3, 1};
  int A[2] = '{2, 1};
  int W[2] = '{8, 1};

  // Model: phase number (8 = flash), ticks left until the phase ends, request latch,
  // which green follows a walk, and whether flashing lamps are lit.
  int m_st[2], m_left[2];
  bit m_pend[2], m_res[2], m_fon[2];

  function automatic int dur(int k, int s);
    case (s)
      1, 4:    return G[k];
      2, 5:    return Y[k];
      3, 6:    return A[k];
      7:       return W[k];
      default: return 1;
    endcase
  endfunction

  task automatic model_step(int k, bit r, bit t, bit p, bit n);
    int nx;
    bit pend_n;
    if (r) begin
      m_st[k] = 0; m_left[k] = 1; m_pend[k] = 0; m_res[k] = 0; m_fon[k] = 0;
      return;
    end
    nx = -1;
    pend_n = m_pend[k] | p;
    if (m_st[k] == 0) nx = 1;
    else if (m_st[k] == 8) begin
      if (t) begin
        if (!n) nx = 3;
        else m_fon[k] = !m_fon[k];
      end
    end else if (t) begin
      if (m_left[k] == 1) begin
        case (m_st[k])
          3, 6: begin
            if (n) nx = 8;
            else if (m_pend[k]) begin nx = 7; m_res[k] = (m_st[k] == 3); end
            else nx = (m_st[k] == 3) ? 4 : 1;
          end
          7:       nx = m_res[k] ? 4 : 1;
          default: nx = m_st[k] + 1;
        endcase
      end else if ((m_st[k] == 1 || m_st[k] == 4) && m_pend[k] && m_left[k] > Y[k])
        m_left[k] = Y[k];
      else
        m_left[k] = m_left[k] - 1;
    end
    if (nx >= 0) begin
      m_st[k] = nx;
      m_left[k] = dur(k, nx);
      if (nx == 8) m_fon[k] = 1;
      if (nx == 7) pend_n = p;
    end
    m_pend[k] = pend_n;
  endtask

  // {phase, ns, ew, walk, ped_pend, remain[5:0]}
  function automatic logic [16:0] exp_vec(int k);
    logic [2:0] ns, ew, ph;
    logic [5:0] rm;
    case (m_st[k])
      1:       begin ns = 3'b010; ew = 3'b100; end
      2:       begin ns = 3'b001; ew = 3'b100; end
      4:       begin ns = 3'b100; ew = 3'b010; end
      5:       begin ns = 3'b100; ew = 3'b001; end
      8:       begin ns = m_fon[k] ? 3'b001 : 3'b000; ew = ns; end
      default: begin ns = 3'b100; ew = 3'b100; end
    endcase
    ph = (m_st[k] == 8) ? 3'd7 : 3'(m_st[k]);
    rm = (m_st[k] == 8) ? 6'd0 : 6'(m_left[k] - 1);
    return {ph, ns, ew, (m_st[k] == 7), m_pend[k], rm};
  endfunction

  function automatic logic [16:0] obs_vec(int k);
    if (k == 0) return {ph0, ns0, ew0, wk0, pp0, rm0};
    return {ph1, ns1, ew1, wk1, pp1, 2'b00, rm1};
  endfunction

  task automatic cyc(input bit t, input bit p, input bit n, input bit r = 1'b0);
    rst = r; tick = t; ped_req = p; night = n;
    for (int k = 0; k < 2; k++) model_step(k, r, t, p, n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 1);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs_vec(k) !== exp_vec(k)) begin
        fails++;
        $display("FAIL reset_model inst%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    tests++;
    if ({ph0, ns0, ew0, wk0, pp0, rm0} !== {3'd0, 3'b100, 3'b100, 1'b0, 1'b0, 6'd0}) begin
      fails++;
      $display("FAIL reset_state got ph=%0d ns=%b ew=%b walk=%b pend=%b rem=%0d want 0/100/100/0/0/0",
               ph0, ns0, ew0, wk0, pp0, rm0);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_normal_cycle;
    int first_ns_g, second_ns_g;
    logic [2:0] prev;
    cyc(0, 0, 0, 1);
    first_ns_g = -1; second_ns_g = -1; prev = 3'd0;
    for (int c = 1; c <= 85; c++) begin
      cyc(1, 0, 0);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          fails++;
          $display("FAIL normal_cycle inst%0d cyc%0d got %h want %h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      if (ph0 == 3'd1 && prev != 3'd1) begin
        if (first_ns_g < 0) first_ns_g = c;
        else if (second_ns_g < 0) second_ns_g = c;
      end
      if (c == 1) begin
        tests++;
        if (ph0 !== 3'd1 || rm0 !== 6'd14) begin
          fails++;
          $display("FAIL first_ns_g got ph=%0d rem=%0d want 1/14", ph0, rm0);
        end
      end
      prev = ph0;
    end
    tests++;
    if (second_ns_g - first_ns_g != 40) begin
      fails++;
      $display("FAIL cycle_period got %0d want 40", second_ns_g - first_ns_g);
    end
    $display("[TB] test_normal_cycle period %0d ticks", second_ns_g - first_ns_g);
  endtask

  task automatic test_ped;
    int n, ped_cycles, after_ped;
    bit pend_at_entry, seen_entry;
    logic [2:0] prev;
    cyc(0, 0, 0, 1);
    n = 0;
    while (!(ph0 == 3'd1 && rm0 == 6'd10) && n < 50) begin cyc(1, 0, 0); n++; end
    tests++;
    if (!(ph0 == 3'd1 && rm0 == 6'd10)) begin
      fails++;
      $display("FAIL ped_wait_rem10 got ph=%0d rem=%0d want 1/10", ph0, rm0);
    end
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    tests++;
    if (rm0 !== 6'd2 || ph0 !== 3'd1) begin
      fails++;
      $display("FAIL ped_shorten got ph=%0d rem=%0d want 1/2", ph0, rm0);
    end
    ped_cycles = 0; after_ped = -1; seen_entry = 0; pend_at_entry = 1; prev = ph0;
    for (int c = 0; c < 40; c++) begin
      cyc(1, 0, 0);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          fails++;
          $display("FAIL ped_seq inst%0d cyc%0d got %h want %h", k, c, obs_vec(k), exp_vec(k));
        end
      end
      if (ph0 == 3'd7 && wk0) begin
        ped_cycles++;
        if (!seen_entry) begin seen_entry = 1; pend_at_entry = pp0; end
      end
      if (prev == 3'd7 && ph0 != 3'd7 && after_ped < 0) after_ped = ph0;
      prev = ph0;
    end
    tests++;
    if (ped_cycles != 8 || after_ped != 4 || pend_at_entry !== 1'b0) begin
      fails++;
      $display("FAIL ped_walk got cycles=%0d next=%0d pend=%b want 8/4/0",
               ped_cycles, after_ped, pend_at_entry);
    end
    $display("[TB] test_ped walk %0d ticks then phase %0d", ped_cycles, after_ped);
  endtask

  task automatic test_night;
    int n;
    cyc(0, 0, 0, 1);
    n = 0;
    while (ph0 != 3'd4 && n < 60) begin cyc(1, 0, 0); n++; end
    n = 0;
    while (!(ph0 == 3'd7 && !wk0) && n < 60) begin
      cyc(1, 0, 1);
      n++;
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          fails++;
          $display("FAIL night_entry inst%0d got %h want %h", k, obs_vec(k), exp_vec(k));
        end
      end
    end
    tests++;
    if (!(ph0 == 3'd7 && !wk0 && ns0 == 3'b001 && ew0 == 3'b001 && rm0 == 6'd0)) begin
      fails++;
      $display("FAIL flash_entry got ph=%0d walk=%b ns=%b ew=%b rem=%0d want 7/0/001/001/0",
               ph0, wk0, ns0, ew0, rm0);
    end
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    tests++;
    if (ns0 !== 3'b000 || ew0 !== 3'b000) begin
      fails++;
      $display("FAIL flash_off got ns=%b ew=%b want 000/000", ns0, ew0);
    end
    cyc(1, 0, 1);
    tests++;
    if (ns0 !== 3'b001 || ew0 !== 3'b001) begin
      fails++;
      $display("FAIL flash_on got ns=%b ew=%b want 001/001", ns0, ew0);
    end
    cyc(1, 0, 0);
    tests++;
    if (ph0 !== 3'd3 || rm0 !== 6'd1 || ns0 !== 3'b100 || ew0 !== 3'b100) begin
      fails++;
      $display("FAIL flash_exit got ph=%0d rem=%0d ns=%b ew=%b want 3/1/100/100", ph0, rm0, ns0, ew0);
    end
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    tests++;
    if (ph0 !== 3'd4 || obs_vec(0) !== exp_vec(0)) begin
      fails++;
      $display("FAIL flash_to_ew_g got ph=%0d vec=%h want 4 vec=%h", ph0, obs_vec(0), exp_vec(0));
    end
    $display("[TB] test_night flash cycle done");
  endtask

  task automatic test_tick_hold;
    int n;
    logic [16:0] snap;
    cyc(0, 0, 0, 1);
    n = 0;
    while (!(ph0 == 3'd2 && rm0 == 6'd1) && n < 60) begin cyc(1, 0, 0); n++; end
    tests++;
    if (!(ph0 == 3'd2 && rm0 == 6'd1)) begin
      fails++;
      $display("FAIL hold_reach got ph=%0d rem=%0d want 2/1", ph0, rm0);
    end
    snap = {3'd2, 3'b001, 3'b100, 1'b0, 1'b0, 6'd1};
    for (int c = 0; c < 100; c++) begin
      cyc(0, 0, 0);
      tests++;
      if (obs_vec(0) !== snap || obs_vec(1) !== exp_vec(1)) begin
        fails++;
        $display("FAIL tick_hold cyc%0d got %h/%h want %h/%h", c, obs_vec(0), obs_vec(1), snap, exp_vec(1));
      end
    end
    $display("[TB] test_tick_hold 100 idle cycles");
  endtask

  task automatic test_reset_in_ped;
    int n;
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0);
    n = 0;
    while (!(ph0 == 3'd7 && rm0 == 6'd4) && n < 80) begin cyc(1, 0, 0); n++; end
    tests++;
    if (!(ph0 == 3'd7 && rm0 == 6'd4 && wk0)) begin
      fails++;
      $display("FAIL rst_ped_reach got ph=%0d rem=%0d walk=%b want 7/4/1", ph0, rm0, wk0);
    end
    cyc(1, 1, 0, 1);
    tests++;
    if ({ph0, ns0, ew0, wk0, pp0, rm0} !== {3'd0, 3'b100, 3'b100, 1'b0, 1'b0, 6'd0}) begin
      fails++;
      $display("FAIL rst_in_ped got ph=%0d ns=%b ew=%b walk=%b pend=%b rem=%0d want 0/100/100/0/0/0",
               ph0, ns0, ew0, wk0, pp0, rm0);
    end
    cyc(1, 0, 0);
    tests++;
    if (ph0 !== 3'd1 || rm0 !== 6'd14 || pp0 !== 1'b0) begin
      fails++;
      $display("FAIL rst_ped_resume got ph=%0d rem=%0d pend=%b want 1/14/0", ph0, rm0, pp0);
    end
    $display("[TB] test_reset_in_ped done");
  endtask

  task automatic test_random;
    bit nl, t, p, r;
    nl = 0;
    cyc(0, 0, 0, 1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 2) nl = ~nl;
      t = ($urandom_range(0, 99) < 60);
      p = ($urandom_range(0, 99) < 8);
      r = ($urandom_range(0, 299) == 0);
      cyc(t, p, nl, r);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          fails++;
          $display("FAIL random inst%0d cyc%0d got %h want %h", k, c, obs_vec(k), exp_vec(k));
        end
      end
    end
    $display("[TB] test_random 4000 cycles");
  endtask

  initial begin
    test_reset;
    test_normal_cycle;
    test_ped;
    test_night;
    test_tick_hold;
    test_reset_in_ped;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
